cp0_exc: RTL and testbench
==========================

CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 int_i  in  6  hardware interrupt lines; sampled each cycle into Cause.IP[7:2].
REQ-004 Memory-stage sources, 1 bit each:
- adel_ifM, adel_memM, adesM: fetch, load and store address errors.
- invalidM: reserved instruction.
- overflowM: arithmetic overflow.
- syscallM, breakM, eretM: syscall, break and eret.
- delayslotM: instruction is in a delay slot.
- validM: slot holds a real instruction.
REQ-005 pcM  in  32  memory-stage PC.
REQ-006 bad_addrM  in  32  faulting data address; used for adel_memM and adesM.
REQ-007 mtc0_weM  in  1  CP0 write enable.
REQ-008 waddr  in  5  CP0 write address.
REQ-009 wdata  in  32  CP0 write data.
REQ-010 raddr  in  5  CP0 read address.
REQ-011 rdata  out  32  combinational read of the currently held register.
REQ-012 flush_exc  out  1  flush E/M/W and redirect fetch; the hazard unit drives flushE, flushM and flushW from it.
REQ-013 newpc  out  32  redirect target; valid while flush_exc=1.
REQ-014 status_o, cause_o, epc_o  out  32 each  register taps.

Function
REQ-015 Registers held: BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14); all other addresses read 0.
REQ-016 Interrupt pending condition: Status.IE=1, Status.EXL=0, and (Cause.IP & Status.IM) != 0.
REQ-017 Exception priority and ExcCode when validM=1:
- 1. pending interrupt 0x00
- 2. adel_ifM 0x04
- 3. invalidM 0x0A
- 4. overflowM 0x0C
- 5. syscallM 0x08
- 6. breakM 0x09
- 7. adel_memM 0x04
- 8. adesM 0x05
REQ-018 eretM with no other event gives flush_exc=1 and newpc=EPC.
REQ-019 Any exception gives flush_exc=1 and newpc=0xBFC00380, combinationally in the same cycle.
REQ-020 On the next edge after an exception, Status.EXL<=1 and Cause.ExcCode<=code.
REQ-021 If EXL was 0 before the exception, also on that edge: Cause.BD<=delayslotM and EPC<=delayslotM ? pcM-4 : pcM; if EXL was 1, EPC and BD are unchanged.
REQ-022 BadVAddr<=pcM on adel_ifM; BadVAddr<=bad_addrM on adel_memM or adesM.
REQ-023 On the next edge after an eret, Status.EXL<=0.
REQ-024 An MTC0 commits only when no exception and no eret occur in that cycle; a simultaneous exception wins and the write is dropped.
REQ-025 Writable fields:
- Status: IM[15:8], EXL[1], IE[0].
- Cause: IP[1:0].
- EPC and Compare: full 32 bits.
- Count: full 32 bits, only when the timer is compiled in.
REQ-026 rdata has no write bypass; same-cycle read returns the old value.
REQ-027 validM=0 suppresses all exception and eret detection.

Reset
REQ-028 While rst=0: Status=0x0040_0000 (BEV=1), and Cause, EPC, BadVAddr, Count and Compare are 0.
REQ-029 While rst=0, flush_exc=0.
REQ-030 Reset mid-exception discards the pending update.

Configuration
REQ-031 Macro CP0_TIMER_EN is defined: Count increments once every 2 clocks through an internal toggle bit and wraps at 0xFFFF_FFFF->0.
REQ-032 With CP0_TIMER_EN defined: Count==Compare (Compare != 0) sets timer-pending (TI, Cause[30]), which ORs into IP7.
REQ-033 With CP0_TIMER_EN defined: writing Compare clears TI, and a same-cycle Count match with a Compare write leaves TI clear.
REQ-034 With CP0_TIMER_EN undefined: Count and Compare read 0, writes to them are ignored, TI=0, and IP7=int_i[5].

Structure
REQ-035 The shared defines header holds CP0 register addresses, ExcCode values, the exception vector 0xBFC00380, and the Status reset value.
REQ-036 One sub-module, exc_prio: combinational priority encoder producing exception present, ExcCode and eret-select.

Verification
REQ-037 IE=1, IM[2]=1, int_i=6'b000001, pcM=0x80001000, delayslotM=0 -> flush_exc=1, newpc=0xBFC00380; next edge EPC=0x80001000, ExcCode=0x00, EXL=1.
REQ-038 overflowM=1 and syscallM=1 together, delayslotM=1, pcM=0x80000104 -> ExcCode=0x0C, EPC=0x80000100, BD=1.
REQ-039 adesM=1, bad_addrM=0x80000003 -> BadVAddr=0x80000003, ExcCode=0x05; then eretM=1 -> newpc=EPC, EXL=0.
REQ-040 mtc0_weM=1 to EPC with wdata=0x1234 and invalidM=1 in the same cycle -> EPC=pcM, not 0x1234; ExcCode=0x0A.
REQ-041 CP0_TIMER_EN defined, Compare=10 -> TI rises at Count=10, about 20 clocks; writing Compare=40 clears TI.
REQ-042 Drive rst=0 for 1 clock mid-stream -> Status=0x00400000, all other registers 0, flush_exc=0.

Source files
------------

// File: rtl/cp0_exc_pkg.sv
// CP0 exception block shared definitions: register addresses, ExcCode values,
// the exception vector, the Status reset value and Cause packing.
// Optional feature macro used by this block: CP0_TIMER_EN (Count/Compare timer).
package cp0_exc_pkg;

  // CP0 register addresses
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Which address (if any) the taken exception loads into BadVAddr
  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_DATA = 2'd2
  } badv_sel_e;

  // Assemble the architectural Cause word from its held fields
  function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exc_code);
    pack_cause = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_exc_prio.sv
// Exception priority encoder: picks the highest-priority memory-stage event,
// its ExcCode, the BadVAddr source, and whether an eret is the only event.
module exc_prio
  import cp0_exc_pkg::*;
(
  input  logic       valid,
  input  logic       int_pending,
  input  logic       adel_if,
  input  logic       invalid,
  input  logic       overflow,
  input  logic       syscall,
  input  logic       brk,
  input  logic       adel_mem,
  input  logic       ades,
  input  logic       eret,
  output logic       exc,
  output logic [4:0] code,
  output logic       eret_sel,
  output badv_sel_e  badv_sel
);

  // Fixed-priority selection; an empty pipeline slot raises nothing
  always_comb begin
    exc      = 1'b0;
    code     = EXC_INT;
    badv_sel = BADV_NONE;
    if (!valid) begin
      exc = 1'b0;
    end else if (int_pending) begin
      exc  = 1'b1;
      code = EXC_INT;
    end else if (adel_if) begin
      exc      = 1'b1;
      code     = EXC_ADEL;
      badv_sel = BADV_PC;
    end else if (invalid) begin
      exc  = 1'b1;
      code = EXC_RI;
    end else if (overflow) begin
      exc  = 1'b1;
      code = EXC_OV;
    end else if (syscall) begin
      exc  = 1'b1;
      code = EXC_SYS;
    end else if (brk) begin
      exc  = 1'b1;
      code = EXC_BP;
    end else if (adel_mem) begin
      exc      = 1'b1;
      code     = EXC_ADEL;
      badv_sel = BADV_DATA;
    end else if (ades) begin
      exc      = 1'b1;
      code     = EXC_ADES;
      badv_sel = BADV_DATA;
    end else begin
      exc = 1'b0;
    end
  end

  assign eret_sel = valid & eret & ~exc;

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception unit: holds BadVAddr/Count/Compare/Status/Cause/EPC, raises
// the pipeline flush and redirect target for exceptions and eret.
// Define CP0_TIMER_EN to build the Count/Compare timer and timer interrupt.
module cp0_exc
  import cp0_exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        adel_ifM,
  input  logic        adel_memM,
  input  logic        adesM,
  input  logic        invalidM,
  input  logic        overflowM,
  input  logic        syscallM,
  input  logic        breakM,
  input  logic        eretM,
  input  logic        delayslotM,
  input  logic        validM,
  input  logic [31:0] pcM,
  input  logic [31:0] bad_addrM,
  input  logic        mtc0_weM,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        flush_exc,
  output logic [31:0] newpc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] cause;
  logic        ip7_src;

  logic        int_pending;
  logic        exc;
  logic [4:0]  exc_code;
  logic        eret_sel;
  badv_sel_e   badv_sel;
  logic        wr_commit;

  assign cause       = pack_cause(cause_bd, cause_ti, cause_ip, cause_exc);
  assign int_pending = status[0] & ~status[1] & (|(cause_ip & status[15:8]));

  exc_prio u_exc_prio (
    .valid       (validM),
    .int_pending (int_pending),
    .adel_if     (adel_ifM),
    .invalid     (invalidM),
    .overflow    (overflowM),
    .syscall     (syscallM),
    .brk         (breakM),
    .adel_mem    (adel_memM),
    .ades        (adesM),
    .eret        (eretM),
    .exc         (exc),
    .code        (exc_code),
    .eret_sel    (eret_sel),
    .badv_sel    (badv_sel)
  );

  // An exception or eret in the same cycle takes precedence over MTC0
  assign wr_commit = mtc0_weM & ~exc & ~eret_sel;

  assign flush_exc = rst & (exc | eret_sel);
  assign newpc     = eret_sel ? epc : EXC_VECTOR;
  assign status_o  = status;
  assign cause_o   = cause;
  assign epc_o     = epc;

`ifdef CP0_TIMER_EN
  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = wr_commit & (waddr == ADDR_COUNT);
  assign wr_compare = wr_commit & (waddr == ADDR_COMPARE);
  assign ip7_src    = int_i[5] | cause_ti;

  // Count advances every other clock; a software write takes precedence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick  <= 1'b0;
      count <= 32'd0;
    end else begin
      tick <= ~tick;
      if (wr_count) begin
        count <= wdata;
      end else if (tick) begin
        count <= count + 32'd1;
      end
    end
  end

  // Compare register and the sticky timer-pending bit it controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else if (wr_compare) begin
      compare  <= wdata;
      cause_ti <= 1'b0;
    end else if ((count == compare) && (compare != 32'd0)) begin
      cause_ti <= 1'b1;
    end
  end
`else
  assign count    = 32'd0;
  assign compare  = 32'd0;
  assign cause_ti = 1'b0;
  assign ip7_src  = int_i[5];
`endif

  // Status: EXL set on exception, cleared on eret, else software fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= STATUS_RESET;
    end else if (exc) begin
      status[1] <= 1'b1;
    end else if (eret_sel) begin
      status[1] <= 1'b0;
    end else if (wr_commit && (waddr == ADDR_STATUS)) begin
      status <= {status[31:16], wdata[15:8], status[7:2], wdata[1:0]};
    end
  end

  // Cause: hardware interrupt sampling, exception recording, soft IP writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_bd  <= 1'b0;
      cause_ip  <= 8'd0;
      cause_exc <= 5'd0;
    end else begin
      cause_ip[7:2] <= {ip7_src, int_i[4:0]};
      if (exc) begin
        cause_exc <= exc_code;
        if (!status[1]) begin
          cause_bd <= delayslotM;
        end
      end else if (wr_commit && (waddr == ADDR_CAUSE)) begin
        cause_ip[1:0] <= wdata[9:8];
      end
    end
  end

  // EPC: restart PC on a first-level exception, otherwise software writable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc <= 32'd0;
    end else if (exc && !status[1]) begin
      epc <= delayslotM ? (pcM - 32'd4) : pcM;
    end else if (wr_commit && (waddr == ADDR_EPC)) begin
      epc <= wdata;
    end
  end

  // BadVAddr: captured from the address that caused an address error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr <= 32'd0;
    end else if (exc && (badv_sel == BADV_PC)) begin
      badvaddr <= pcM;
    end else if (exc && (badv_sel == BADV_DATA)) begin
      badvaddr <= bad_addrM;
    end
  end

  // Read port returns held values only, no forwarding of this cycle's write
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      ADDR_BADVADDR: rdata = badvaddr;
      ADDR_COUNT:    rdata = count;
      ADDR_COMPARE:  rdata = compare;
      ADDR_STATUS:   rdata = status;
      ADDR_CAUSE:    rdata = cause;
      ADDR_EPC:      rdata = epc;
      default:       rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed vector table, hand-written
// corner sequences, then randomized traffic against a reference model.
module tb_cp0_exc;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        adel_ifM, adel_memM, adesM, invalidM, overflowM;
  logic        syscallM, breakM, eretM, delayslotM, validM;
  logic [31:0] pcM, bad_addrM, wdata;
  logic        mtc0_weM;
  logic [4:0]  waddr, raddr;
  logic [31:0] rdata, newpc, status_o, cause_o, epc_o;
  logic        flush_exc;

  cp0_exc dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .adel_ifM(adel_ifM), .adel_memM(adel_memM), .adesM(adesM),
    .invalidM(invalidM), .overflowM(overflowM), .syscallM(syscallM),
    .breakM(breakM), .eretM(eretM), .delayslotM(delayslotM), .validM(validM),
    .pcM(pcM), .bad_addrM(bad_addrM), .mtc0_weM(mtc0_weM), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .flush_exc(flush_exc),
    .newpc(newpc), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  logic [31:0] m_status, m_epc, m_bad, m_count, m_cmp;
  logic        m_bd, m_ti, m_half;
  logic [7:0]  m_ip;
  logic [4:0]  m_code;
  logic [4:0]  prio_code [8] = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000;
    m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
    m_bd = 0; m_ti = 0; m_half = 0; m_ip = 0; m_code = 0;
  endtask

  // Which event wins this cycle: index into priority list, or -1
  task automatic model_eval(output bit exc, output bit eret, output int idx);
    bit ev [8];
    bit pend;
    pend = m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 8'd0);
    ev = '{pend, adel_ifM, invalidM, overflowM, syscallM, breakM, adel_memM, adesM};
    exc = 0; idx = -1;
    for (int i = 0; i < 8; i++)
      if (validM && ev[i] && !exc) begin exc = 1; idx = i; end
    eret = validM && eretM && !exc;
  endtask

  task automatic model_clock();
    bit exc, eret, wr;
    int idx;
    logic [7:0] n_ip;
    model_eval(exc, eret, idx);
    wr = mtc0_weM && !exc && !eret;
    n_ip = {int_i[5] | (TIMER && m_ti), int_i[4:0], m_ip[1:0]};
    if (exc) begin
      m_code = prio_code[idx];
      if (!m_status[1]) begin
        m_bd  = delayslotM;
        m_epc = delayslotM ? pcM - 32'd4 : pcM;
      end
      m_status[1] = 1'b1;
      if (idx == 1) m_bad = pcM;
      if (idx == 6 || idx == 7) m_bad = bad_addrM;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      if (waddr == 5'd12) begin m_status[15:8] = wdata[15:8]; m_status[1:0] = wdata[1:0]; end
      if (waddr == 5'd13) n_ip[1:0] = wdata[9:8];
      if (waddr == 5'd14) m_epc = wdata;
    end
    m_ip = n_ip;
    if (TIMER) begin
      if (wr && waddr == 5'd11) m_ti = 0;
      else if (m_count == m_cmp && m_cmp != 0) m_ti = 1;
      if (wr && waddr == 5'd11) m_cmp = wdata;
      if (wr && waddr == 5'd9) m_count = wdata;
      else if (m_half) m_count = m_count + 32'd1;
      m_half = !m_half;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    int_i = 0; adel_ifM = 0; adel_memM = 0; adesM = 0; invalidM = 0;
    overflowM = 0; syscallM = 0; breakM = 0; eretM = 0; delayslotM = 0;
    validM = 0; pcM = 32'h8000_0000; bad_addrM = 0; mtc0_weM = 0;
    waddr = 0; wdata = 0; raddr = 5'd12;
  endtask

  // One clock with current inputs; starts and ends at a falling edge
  task automatic step();
    bit exc, eret;
    int idx;
    #1;
    model_eval(exc, eret, idx);
    chk("flush", {31'd0, flush_exc}, {31'd0, exc | eret});
    if (exc || eret) chk("newpc", newpc, eret ? m_epc : 32'hBFC0_0380);
    chk("rdata", rdata, m_read(raddr));
    @(posedge clk);
    model_clock();
    #1;
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause());
    chk("epc", epc_o, m_epc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    model_reset();
    raddr = 5'd8;
    #1;
    chk("rst_flush", {31'd0, flush_exc}, 32'd0);
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_badv", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    raddr = 5'd12;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); mtc0_weM = 1; waddr = a; wdata = d;
    step();
    idle();
  endtask

  typedef struct {
    logic [7:0]  src;   // adel_if, invalid, overflow, syscall, break, adel_mem, ades, eret
    logic        valid;
    logic        ds;
    logic [31:0] pc;
    logic        exp_flush;
    logic [31:0] exp_newpc;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic        exp_exl;
  } vec_t;

  vec_t tbl [11];

  initial begin
    bit seen;
    int waited;
    logic [4:0] addr_list [7];
    addr_list = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    tbl[0]  = '{8'b0011_0000, 1'b1, 1'b1, 32'h8000_0104, 1'b1, 32'hBFC0_0380, 5'h0C, 32'h8000_0100, 1'b1, 1'b1};
    tbl[1]  = '{8'b0100_0000, 1'b1, 1'b0, 32'h8000_0200, 1'b1, 32'hBFC0_0380, 5'h0A, 32'h8000_0200, 1'b0, 1'b1};
    tbl[2]  = '{8'b1100_0000, 1'b1, 1'b0, 32'h8000_0300, 1'b1, 32'hBFC0_0380, 5'h04, 32'h8000_0300, 1'b0, 1'b1};
    tbl[3]  = '{8'b0001_1000, 1'b1, 1'b0, 32'h8000_0400, 1'b1, 32'hBFC0_0380, 5'h08, 32'h8000_0400, 1'b0, 1'b1};
    tbl[4]  = '{8'b0000_1100, 1'b1, 1'b0, 32'h8000_0500, 1'b1, 32'hBFC0_0380, 5'h09, 32'h8000_0500, 1'b0, 1'b1};
    tbl[5]  = '{8'b0000_0110, 1'b1, 1'b0, 32'h8000_0600, 1'b1, 32'hBFC0_0380, 5'h04, 32'h8000_0600, 1'b0, 1'b1};
    tbl[6]  = '{8'b0000_0010, 1'b1, 1'b1, 32'h8000_0704, 1'b1, 32'hBFC0_0380, 5'h05, 32'h8000_0700, 1'b1, 1'b1};
    tbl[7]  = '{8'b0010_0000, 1'b0, 1'b0, 32'h8000_0800, 1'b0, 32'h0000_0000, 5'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8]  = '{8'b0000_0001, 1'b1, 1'b0, 32'h8000_0900, 1'b1, 32'h0000_0000, 5'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{8'b0001_0001, 1'b1, 1'b0, 32'h8000_0A00, 1'b1, 32'hBFC0_0380, 5'h08, 32'h8000_0A00, 1'b0, 1'b1};
    tbl[10] = '{8'b0000_0000, 1'b1, 1'b1, 32'h8000_0B00, 1'b0, 32'h0000_0000, 5'h00, 32'h0000_0000, 1'b0, 1'b0};

    rst = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // ---- table of single-cycle events, each from a fresh reset ----
    for (int i = 0; i < 11; i++) begin
      do_reset();
      {adel_ifM, invalidM, overflowM, syscallM, breakM, adel_memM, adesM, eretM} = tbl[i].src;
      validM = tbl[i].valid; delayslotM = tbl[i].ds; pcM = tbl[i].pc;
      bad_addrM = 32'h0000_0ABC;
      #1;
      chk($sformatf("tbl%0d_flush", i), {31'd0, flush_exc}, {31'd0, tbl[i].exp_flush});
      if (tbl[i].exp_flush) chk($sformatf("tbl%0d_newpc", i), newpc, tbl[i].exp_newpc);
      step();
      chk($sformatf("tbl%0d_code", i), {27'd0, cause_o[6:2]}, {27'd0, tbl[i].exp_code});
      chk($sformatf("tbl%0d_epc", i), epc_o, tbl[i].exp_epc);
      chk($sformatf("tbl%0d_bd", i), {31'd0, cause_o[31]}, {31'd0, tbl[i].exp_bd});
      chk($sformatf("tbl%0d_exl", i), {31'd0, status_o[1]}, {31'd0, tbl[i].exp_exl});
    end

    // ---- hardware interrupt on IP2 ----
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'b000001;
    step();
    validM = 1; pcM = 32'h8000_1000; delayslotM = 0;
    #1;
    chk("int_flush", {31'd0, flush_exc}, 32'd1);
    chk("int_newpc", newpc, 32'hBFC0_0380);
    step();
    chk("int_epc", epc_o, 32'h8000_1000);
    chk("int_code", {27'd0, cause_o[6:2]}, 32'd0);
    chk("int_exl", {31'd0, status_o[1]}, 32'd1);
    idle(); int_i = 6'b000001;
    step();

    // ---- store address error then eret ----
    do_reset();
    validM = 1; adesM = 1; bad_addrM = 32'h8000_0003; pcM = 32'h8000_2000;
    step();
    idle(); raddr = 5'd8;
    #1;
    chk("ades_badv", rdata, 32'h8000_0003);
    chk("ades_code", {27'd0, cause_o[6:2]}, 32'h5);
    step();
    validM = 1; eretM = 1;
    #1;
    chk("eret_flush", {31'd0, flush_exc}, 32'd1);
    chk("eret_newpc", newpc, 32'h8000_2000);
    step();
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // ---- MTC0 dropped by a same-cycle exception; nested exception ----
    do_reset();
    mtc0_weM = 1; waddr = 5'd14; wdata = 32'h0000_1234;
    validM = 1; invalidM = 1; pcM = 32'h8000_3000;
    step();
    chk("mtc0_drop_epc", epc_o, 32'h8000_3000);
    chk("mtc0_drop_code", {27'd0, cause_o[6:2]}, 32'h0A);
    idle(); validM = 1; syscallM = 1; pcM = 32'h8000_4000;
    step();
    chk("nested_epc", epc_o, 32'h8000_3000);
    chk("nested_code", {27'd0, cause_o[6:2]}, 32'h08);
    idle(); mtc0_weM = 1; waddr = 5'd14; wdata = 32'h0000_5555; raddr = 5'd14;
    #1;
    chk("no_bypass", rdata, 32'h8000_3000);
    step();
    chk("epc_written", epc_o, 32'h0000_5555);

    // ---- one-clock reset in the middle of an exception ----
    idle(); validM = 1; overflowM = 1; pcM = 32'h8000_6000;
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    raddr = 5'd8;
    #1;
    chk("midrst_flush", {31'd0, flush_exc}, 32'd0);
    chk("midrst_status", status_o, 32'h0040_0000);
    chk("midrst_cause", cause_o, 32'd0);
    chk("midrst_epc", epc_o, 32'd0);
    chk("midrst_badv", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    step();

    // ---- timer ----
    do_reset();
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd10);
    seen = 0; waited = 0;
    while (!seen && waited < 100) begin
      raddr = 5'd9;
      step();
      waited++;
      if (cause_o[30]) seen = 1;
    end
    chk("ti_rise", {31'd0, seen}, 32'd1);
    raddr = 5'd9;
    #1;
    chk("ti_count", rdata, 32'd10);
    mtc0(5'd11, 32'd40);
    chk("ti_clear", {31'd0, cause_o[30]}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin raddr = 5'd9; step(); end
`else
    mtc0(5'd9, 32'd5);
    mtc0(5'd11, 32'd7);
    raddr = 5'd9;
    #1;
    chk("count_zero", rdata, 32'd0);
    raddr = 5'd11;
    #1;
    chk("compare_zero", rdata, 32'd0);
    chk("ti_zero", {31'd0, cause_o[30]}, 32'd0);
    step();
`endif

    // ---- randomized traffic against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        int_i      = 6'($urandom);
        validM     = ($urandom_range(0, 3) != 0);
        adel_ifM   = ($urandom_range(0, 19) == 0);
        invalidM   = ($urandom_range(0, 19) == 0);
        overflowM  = ($urandom_range(0, 19) == 0);
        syscallM   = ($urandom_range(0, 19) == 0);
        breakM     = ($urandom_range(0, 19) == 0);
        adel_memM  = ($urandom_range(0, 19) == 0);
        adesM      = ($urandom_range(0, 19) == 0);
        eretM      = ($urandom_range(0, 7) == 0);
        delayslotM = 1'($urandom);
        pcM        = $urandom & 32'hFFFF_FFFC;
        bad_addrM  = $urandom;
        mtc0_weM   = ($urandom_range(0, 2) == 0);
        waddr      = addr_list[$urandom_range(0, 6)];
        wdata      = $urandom;
        raddr      = addr_list[$urandom_range(0, 6)];
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
